// File: rtl/lane_pkg.sv
// Shared types, sizes and lane-walk helpers for the lane result collector.
package lane_pkg;

    localparam int LANE_W         = 12;
    localparam int NUM_LANES      = 3;
    localparam int BUS_W          = 41;
    localparam int SETTLE_CYC_DEF = 2;

    localparam logic [NUM_LANES-1:0] LANE_MASK_DEF = 3'b101;

    // Lane index 3 does not exist on a three-lane bus, so it doubles as "no lane".
    localparam logic [1:0] LANE_NONE = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_EMIT    = 3'd3,
        ST_DONE    = 3'd4
    } lane_state_e;

    // Lowest enabled lane strictly above cur, or LANE_NONE.
    function automatic logic [1:0] next_lane(input logic [NUM_LANES-1:0] mask,
                                             input logic [1:0]           cur);
        logic [1:0] res;
        res = LANE_NONE;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (mask[k] && (k > int'(cur))) begin
                res = 2'(k);
            end
        end
        return res;
    endfunction

    function automatic logic [1:0] first_lane(input logic [NUM_LANES-1:0] mask);
        return mask[0] ? 2'd0 : next_lane(mask, 2'd0);
    endfunction

endpackage

// File: rtl/lane_capture_regs.sv
// Per-lane snapshot registers: loaded on the capture strobe for enabled lanes,
// read back by lane index.
module lane_capture_regs #(
    parameter int LANE_W    = 12,
    parameter int NUM_LANES = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cap_en_i,
    input  logic [NUM_LANES-1:0]          mask_i,
    input  logic [NUM_LANES*LANE_W-1:0]   lanes_i,
    input  logic [1:0]                    rd_idx_i,
    output logic [LANE_W-1:0]             rd_data_o
);

    logic [NUM_LANES-1:0][LANE_W-1:0] regs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (cap_en_i && mask_i[k]) begin
                    regs_q[k] <= lanes_i[k*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Out-of-range indices read as zero.
    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (rd_idx_i == 2'(k)) begin
                rd_data_o = regs_q[k];
            end
        end
    end

endmodule

// File: rtl/lane_result_collector.sv
// Waits for the lane datapath to settle after a launch, snapshots the enabled
// lanes and streams them out one per transfer, lowest index first.
module lane_result_collector #(
    parameter int                               BUS_W      = lane_pkg::BUS_W,
    parameter int                               LANE_W     = lane_pkg::LANE_W,
    parameter int                               NUM_LANES  = lane_pkg::NUM_LANES,
    parameter logic [lane_pkg::NUM_LANES-1:0]   LANE_MASK  = lane_pkg::LANE_MASK_DEF,
    parameter int                               SETTLE_CYC = lane_pkg::SETTLE_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic              busy_o,
    input  logic [BUS_W-1:0]  c_bus_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [LANE_W-1:0] out_data_o,
    output logic [1:0]        out_lane_o,
    output logic              out_last_o,
    output logic              done_o,
    output logic [2:0]        dbg_state_o
);

    import lane_pkg::*;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    // Handshake: a transfer happens on a rising edge where out_valid_o and
    // out_ready_i are both high. Once out_valid_o rises it stays high, with
    // out_data_o/out_lane_o/out_last_o stable, until that transfer occurs.

    lane_state_e       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        lane_q, lane_d;
    logic [LANE_W-1:0] data_q, data_d;
    logic              cap_en;
    logic [1:0]        nxt_lane;
    logic [1:0]        first_idx;
    logic [LANE_W-1:0] rd_data;
    logic [LANE_W-1:0] first_data;
    logic              unused_hi_bits;

    // Bus bits above the last lane carry nothing meaningful.
    assign unused_hi_bits = ^c_bus_i[BUS_W-1:NUM_LANES*LANE_W];

    assign nxt_lane  = next_lane(LANE_MASK, lane_q);
    assign first_idx = first_lane(LANE_MASK);

    // The first lane is taken straight off the bus during CAPTURE so it can be
    // presented the very next cycle; later lanes come from the snapshot.
    always_comb begin
        first_data = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (first_idx == 2'(k)) begin
                first_data = c_bus_i[k*LANE_W +: LANE_W];
            end
        end
    end

    lane_capture_regs #(
        .LANE_W    (LANE_W),
        .NUM_LANES (NUM_LANES)
    ) u_capture_regs (
        .clk       (clk),
        .rst_n     (rst_n),
        .cap_en_i  (cap_en),
        .mask_i    (LANE_MASK),
        .lanes_i   (c_bus_i[NUM_LANES*LANE_W-1:0]),
        .rd_idx_i  (nxt_lane),
        .rd_data_o (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lane_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        data_d  = data_q;
        cap_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CAPTURE: begin
                cap_en = 1'b1;
                if (LANE_MASK == '0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_EMIT;
                    lane_d  = first_idx;
                    data_d  = first_data;
                end
            end
            ST_EMIT: begin
                if (out_ready_i) begin
                    if (nxt_lane == LANE_NONE) begin
                        state_d = ST_DONE;
                    end else begin
                        lane_d = nxt_lane;
                        data_d = rd_data;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign out_valid_o = (state_q == ST_EMIT);
    assign out_last_o  = out_valid_o && (nxt_lane == LANE_NONE);
    assign done_o      = (state_q == ST_DONE);
    assign out_data_o  = data_q;
    assign out_lane_o  = lane_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lane_result_collector.sv
// Directed bench for lane_result_collector: default, all-lanes and no-lanes builds.
module tb_lane_result_collector;

  import lane_pkg::*;

  localparam logic [40:0] PAT = {5'h1F, 12'h3F1, 12'h777, 12'hA5C};

  logic clk;
  logic rst_n;

  logic        start_def, ready_def;
  logic [40:0] cbus_def;
  logic        busy_def, valid_def, last_def, done_def;
  logic [11:0] data_def;
  logic [1:0]  lane_def;
  logic [2:0]  dbg_def;

  logic        start_all, ready_all;
  logic [40:0] cbus_all;
  logic        busy_all, valid_all, last_all, done_all;
  logic [11:0] data_all;
  logic [1:0]  lane_all;
  logic [2:0]  dbg_all;

  logic        start_none, ready_none;
  logic [40:0] cbus_none;
  logic        busy_none, valid_none, last_none, done_none;
  logic [11:0] data_none;
  logic [1:0]  lane_none;
  logic [2:0]  dbg_none;

  // {busy, valid, last, done, lane, data}
  logic [17:0] obs_def, obs_all, obs_none;
  assign obs_def  = {busy_def, valid_def, last_def, done_def, lane_def, data_def};
  assign obs_all  = {busy_all, valid_all, last_all, done_all, lane_all, data_all};
  assign obs_none = {busy_none, valid_none, last_none, done_none, lane_none, data_none};

  int checks;
  int failures;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  lane_result_collector u_def (
    .clk(clk), .rst_n(rst_n), .start_i(start_def), .busy_o(busy_def),
    .c_bus_i(cbus_def), .out_valid_o(valid_def), .out_ready_i(ready_def),
    .out_data_o(data_def), .out_lane_o(lane_def), .out_last_o(last_def),
    .done_o(done_def), .dbg_state_o(dbg_def)
  );

  lane_result_collector #(.LANE_MASK(3'b111), .SETTLE_CYC(1)) u_all (
    .clk(clk), .rst_n(rst_n), .start_i(start_all), .busy_o(busy_all),
    .c_bus_i(cbus_all), .out_valid_o(valid_all), .out_ready_i(ready_all),
    .out_data_o(data_all), .out_lane_o(lane_all), .out_last_o(last_all),
    .done_o(done_all), .dbg_state_o(dbg_all)
  );

  lane_result_collector #(.LANE_MASK(3'b000), .SETTLE_CYC(2)) u_none (
    .clk(clk), .rst_n(rst_n), .start_i(start_none), .busy_o(busy_none),
    .c_bus_i(cbus_none), .out_valid_o(valid_none), .out_ready_i(ready_none),
    .out_data_o(data_none), .out_lane_o(lane_none), .out_last_o(last_none),
    .done_o(done_none), .dbg_state_o(dbg_none)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_def = 0; ready_def = 1; cbus_def = '0;
    start_all = 0; ready_all = 1; cbus_all = '0;
    start_none = 0; ready_none = 1; cbus_none = '0;
    step(); step();
    checks++;
    if ({obs_def, obs_all, obs_none} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h/%h/%h exp=0", obs_def, obs_all, obs_none);
    end
    checks++;
    if (dbg_def !== 3'(ST_IDLE)) begin
      failures++;
      $display("FAIL reset_state got=%0d exp=%0d", dbg_def, ST_IDLE);
    end
    rst_n = 1'b1;
    step();
  endtask

  // Ready high; bus switched to all-ones after capture must not leak out.
  task automatic test_basic();
    logic [17:0] e [1:7];
    for (int c = 1; c <= 3; c++) e[c] = {4'b1000, 2'd0, 12'h000};
    e[4] = {4'b1100, 2'd0, 12'hA5C};
    e[5] = {4'b1110, 2'd2, 12'h3F1};
    e[6] = {4'b1001, 2'd2, 12'h3F1};
    e[7] = {4'b0000, 2'd2, 12'h3F1};
    cbus_def = PAT; ready_def = 1; start_def = 1;
    for (int c = 1; c <= 7; c++) begin
      step();
      start_def = 0;
      if (c == 4) cbus_def = '1;
      checks++;
      if (obs_def !== e[c]) begin
        failures++;
        $display("FAIL basic t+%0d got=%h exp=%h", c, obs_def, e[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] e [1:10];
    for (int c = 1; c <= 3; c++) e[c] = {4'b1000, 2'd2, 12'h3F1};
    for (int c = 4; c <= 7; c++) e[c] = {4'b1100, 2'd0, 12'hA5C};
    e[8]  = {4'b1110, 2'd2, 12'h3F1};
    e[9]  = {4'b1001, 2'd2, 12'h3F1};
    e[10] = {4'b0000, 2'd2, 12'h3F1};
    cbus_def = PAT; ready_def = 0; start_def = 1;
    for (int c = 1; c <= 10; c++) begin
      step();
      start_def = 0;
      if (c == 7) ready_def = 1;
      checks++;
      if (obs_def !== e[c]) begin
        failures++;
        $display("FAIL backpressure t+%0d got=%h exp=%h", c, obs_def, e[c]);
      end
    end
  endtask

  // start held high through the frame and its DONE cycle, then one more
  // cycle: the extra cycle is the earliest legal restart.
  task automatic test_ignored_start_restart();
    logic [17:0] e [1:14];
    for (int c = 1; c <= 3; c++) e[c] = {4'b1000, 2'd2, 12'h3F1};
    e[4] = {4'b1100, 2'd0, 12'hA5C};
    e[5] = {4'b1110, 2'd2, 12'h3F1};
    e[6] = {4'b1001, 2'd2, 12'h3F1};
    e[7] = {4'b0000, 2'd2, 12'h3F1};
    for (int c = 8; c <= 14; c++) e[c] = e[c-7];
    cbus_def = PAT; ready_def = 1; start_def = 1;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c == 8) start_def = 0;
      checks++;
      if (obs_def !== e[c]) begin
        failures++;
        $display("FAIL ignored_start t+%0d got=%h exp=%h", c, obs_def, e[c]);
      end
    end
  endtask

  task automatic test_reset_mid_emit();
    logic [17:0] e [1:7];
    cbus_def = PAT; ready_def = 0; start_def = 1;
    for (int c = 1; c <= 4; c++) begin
      step();
      start_def = 0;
    end
    checks++;
    if (obs_def !== {4'b1100, 2'd0, 12'hA5C}) begin
      failures++;
      $display("FAIL rst_mid_stalled got=%h exp=%h", obs_def, {4'b1100, 2'd0, 12'hA5C});
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_def !== '0) begin
      failures++;
      $display("FAIL rst_mid_async got=%h exp=0", obs_def);
    end
    for (int c = 1; c <= 3; c++) begin
      step();
      checks++;
      if (obs_def !== '0) begin
        failures++;
        $display("FAIL rst_mid_held cyc=%0d got=%h exp=0", c, obs_def);
      end
    end
    rst_n = 1'b1;
    ready_def = 1;
    step();
    checks++;
    if (obs_def !== '0) begin
      failures++;
      $display("FAIL rst_mid_release got=%h exp=0", obs_def);
    end
    for (int c = 1; c <= 3; c++) e[c] = {4'b1000, 2'd0, 12'h000};
    e[4] = {4'b1100, 2'd0, 12'hA5C};
    e[5] = {4'b1110, 2'd2, 12'h3F1};
    e[6] = {4'b1001, 2'd2, 12'h3F1};
    e[7] = {4'b0000, 2'd2, 12'h3F1};
    start_def = 1;
    for (int c = 1; c <= 7; c++) begin
      step();
      start_def = 0;
      checks++;
      if (obs_def !== e[c]) begin
        failures++;
        $display("FAIL rst_mid_restart t+%0d got=%h exp=%h", c, obs_def, e[c]);
      end
    end
  endtask

  task automatic test_param_sweep();
    logic [17:0] ea [1:7];
    logic [17:0] en [1:7];
    ea[1] = {4'b1000, 2'd0, 12'h000};
    ea[2] = {4'b1000, 2'd0, 12'h000};
    ea[3] = {4'b1100, 2'd0, 12'hA5C};
    ea[4] = {4'b1100, 2'd1, 12'h777};
    ea[5] = {4'b1110, 2'd2, 12'h3F1};
    ea[6] = {4'b1001, 2'd2, 12'h3F1};
    ea[7] = {4'b0000, 2'd2, 12'h3F1};
    for (int c = 1; c <= 3; c++) en[c] = {4'b1000, 2'd0, 12'h000};
    en[4] = {4'b1001, 2'd0, 12'h000};
    for (int c = 5; c <= 7; c++) en[c] = '0;
    cbus_all = PAT; ready_all = 1; start_all = 1;
    cbus_none = PAT; ready_none = 1; start_none = 1;
    for (int c = 1; c <= 7; c++) begin
      step();
      start_all = 0;
      start_none = 0;
      checks++;
      if (obs_all !== ea[c]) begin
        failures++;
        $display("FAIL mask111 t+%0d got=%h exp=%h", c, obs_all, ea[c]);
      end
      checks++;
      if (obs_none !== en[c]) begin
        failures++;
        $display("FAIL mask000 t+%0d got=%h exp=%h", c, obs_none, en[c]);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_ignored_start_restart();
    test_reset_mid_emit();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
